// File: rtl/qam_symbol_scheduler_if.sv
// Byte-source handshake and 16-QAM symbol output bundle
// for the QAM symbol scheduler.
interface qam_symbol_scheduler_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;
    logic [3:0] sym_nibble;
    logic       sym_valid;
    logic       tx_active;
    logic       underrun;

    modport slave (
        input  s_data, s_valid, s_last,
        output s_ready, sym_nibble, sym_valid, tx_active, underrun
    );

    modport master (
        output s_data, s_valid, s_last,
        input  s_ready, sym_nibble, sym_valid, tx_active, underrun
    );
endinterface

// File: rtl/qam_symbol_scheduler.sv
// Frames a byte stream into PREAMBLE/PAYLOAD/GUARD bursts of
// 4-bit symbols, each held SYM_DIV clocks, for a 16-QAM mapper.
module qam_symbol_scheduler #(
    parameter int unsigned SYM_DIV      = 4,
    parameter int unsigned PREAMBLE_LEN = 8,
    parameter int unsigned GUARD_LEN    = 2,
    parameter logic [3:0]  PRE_A        = 4'h0,
    parameter logic [3:0]  PRE_B        = 4'hF
) (
    input  logic                  clk,
    input  logic                  rst,
    qam_symbol_scheduler_if.slave bus
);
    localparam int unsigned CW = $clog2(SYM_DIV);
    localparam logic [CW-1:0] CNT_MAX  = CW'(SYM_DIV - 1);
    localparam logic [7:0]    PRE_LAST = 8'(PREAMBLE_LEN - 1);
    localparam logic [7:0]    GRD_LAST = 8'(GUARD_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRE,
        S_PAY,
        S_GRD
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    idx_q, idx_d;
    logic          nib_sel_q, nib_sel_d;
    logic [7:0]    byte_q, byte_d;
    logic          last_q, last_d;
    logic [3:0]    nib_q, nib_d;
    logic          sv_q, sv_d;
    logic          tx_q, tx_d;
    logic          ur_q, ur_d;

    logic tick;
    logic fetch;

    assign tick = (cnt_q == CNT_MAX);

    // A byte is needed after the last preamble symbol and after
    // each low nibble of a byte that was not flagged last.
    assign fetch = tick &&
        ((state_q == S_PRE && idx_q == PRE_LAST) ||
         (state_q == S_PAY && !nib_sel_q && !last_q));

    assign bus.s_ready    = fetch;
    assign bus.sym_nibble = nib_q;
    assign bus.sym_valid  = sv_q;
    assign bus.tx_active  = tx_q;
    assign bus.underrun   = ur_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = (state_q == S_IDLE || tick) ? '0 : cnt_q + CW'(1);
        idx_d     = idx_q;
        nib_sel_d = nib_sel_q;
        byte_d    = byte_q;
        last_d    = last_q;
        nib_d     = nib_q;
        sv_d      = 1'b0;
        ur_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.s_valid) begin
                    state_d = S_PRE;
                    idx_d   = '0;
                    nib_d   = PRE_A;
                    sv_d    = 1'b1;
                end
            end
            S_PRE: begin
                if (tick && !fetch) begin
                    idx_d = idx_q + 8'd1;
                    nib_d = idx_q[0] ? PRE_A : PRE_B;
                    sv_d  = 1'b1;
                end
            end
            S_PAY: begin
                if (tick && nib_sel_q) begin
                    nib_d     = byte_q[3:0];
                    nib_sel_d = 1'b0;
                    sv_d      = 1'b1;
                end else if (tick && last_q) begin
                    state_d = S_GRD;
                    idx_d   = '0;
                    nib_d   = '0;
                end
            end
            S_GRD: begin
                if (tick) begin
                    if (idx_q == GRD_LAST) begin
                        state_d = S_IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Missing byte at a fetch point aborts into the guard.
        if (fetch) begin
            if (bus.s_valid) begin
                byte_d    = bus.s_data;
                last_d    = bus.s_last;
                nib_d     = bus.s_data[7:4];
                nib_sel_d = 1'b1;
                state_d   = S_PAY;
                sv_d      = 1'b1;
            end else begin
                ur_d    = 1'b1;
                state_d = S_GRD;
                idx_d   = '0;
                nib_d   = '0;
            end
        end

        tx_d = (state_d == S_PRE) || (state_d == S_PAY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            nib_sel_q <= 1'b0;
            byte_q    <= '0;
            last_q    <= 1'b0;
            nib_q     <= '0;
            sv_q      <= 1'b0;
            tx_q      <= 1'b0;
            ur_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            nib_sel_q <= nib_sel_d;
            byte_q    <= byte_d;
            last_q    <= last_d;
            nib_q     <= nib_d;
            sv_q      <= sv_d;
            tx_q      <= tx_d;
            ur_q      <= ur_d;
        end
    end
endmodule

// File: tb/tb_qam_symbol_scheduler.sv
// Bench for qam_symbol_scheduler: per-cycle comparison against
// a burst schedule computed from symbol timing arithmetic.
module tb_qam_symbol_scheduler;
    localparam int D = 4;
    localparam int P = 4;
    localparam int G = 2;
    localparam logic [3:0] PA = 4'h0;
    localparam logic [3:0] PB = 4'hF;
    localparam int MAXC = 4096;

    logic clk = 1'b0;
    logic rst;

    qam_symbol_scheduler_if bus ();

    qam_symbol_scheduler #(
        .SYM_DIV(D),
        .PREAMBLE_LEN(P),
        .GUARD_LEN(G),
        .PRE_A(PA),
        .PRE_B(PB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [3:0] e_nib [MAXC];
    bit         e_sv  [MAXC];
    bit         e_tx  [MAXC];
    bit         e_rdy [MAXC];
    bit         e_ur  [MAXC];
    bit         d_rst [MAXC];
    bit         d_val [MAXC];
    bit         d_last[MAXC];
    logic [7:0] d_dat [MAXC];
    logic [7:0] bq    [8];

    int cur;
    int errs;
    int checks;
    int acc;

    task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cur, got, exp);
        end
    endtask

    function automatic void clear(int from);
        for (int c = from; c < MAXC; c++) begin
            e_nib[c]  = 4'h0;
            e_sv[c]   = 1'b0;
            e_tx[c]   = 1'b0;
            e_rdy[c]  = 1'b0;
            e_ur[c]   = 1'b0;
            d_rst[c]  = 1'b0;
            d_val[c]  = 1'b0;
            d_last[c] = 1'b0;
            d_dat[c]  = 8'h00;
        end
    endfunction

    // 0: valid only where required, 1: random, 2: held high
    function automatic bit mv(int mode);
        if (mode == 0) return 1'b0;
        if (mode == 1) return 1'($urandom_range(0, 1));
        return 1'b1;
    endfunction

    function automatic void put_sym(int t, logic [3:0] nib);
        for (int c = t; c < t + D; c++) begin
            e_nib[c] = nib;
            e_tx[c]  = 1'b1;
            e_sv[c]  = (c == t);
        end
    endfunction

    // Schedules a burst whose start request is seen in IDLE cycle
    // t0; byte 'absent' (or -1) is missing at its fetch point.
    // Returns the cycle in which IDLE is re-entered.
    function automatic int plan(int t0, int n, int absent, int mode);
        int  pos;
        int  prev;
        bit  stop;
        d_val[t0]  = 1'b1;
        d_dat[t0]  = bq[0];
        d_last[t0] = (n == 1);
        for (int k = 0; k < P; k++)
            put_sym(t0 + 1 + k * D, (k % 2 == 1) ? PB : PA);
        pos  = t0 + 1 + P * D;
        prev = t0;
        stop = 1'b0;
        for (int j = 0; j < n; j++) begin
            if (!stop) begin
                for (int c = prev + 1; c < pos; c++) begin
                    d_dat[c]  = bq[j];
                    d_last[c] = (j == n - 1);
                    d_val[c]  = mv(mode);
                end
                d_val[pos - 1] = (j != absent);
                e_rdy[pos - 1] = 1'b1;
                prev = pos - 1;
                if (j == absent) begin
                    e_ur[pos] = 1'b1;
                    stop = 1'b1;
                end else begin
                    put_sym(pos, bq[j][7:4]);
                    put_sym(pos + D, bq[j][3:0]);
                    pos += 2 * D;
                end
            end
        end
        for (int c = prev + 1; c < pos + G * D; c++) begin
            d_dat[c]  = 8'($urandom);
            d_last[c] = 1'($urandom_range(0, 1));
            d_val[c]  = mv(mode);
        end
        return pos + G * D;
    endfunction

    task automatic step();
        rst         = d_rst[cur];
        bus.s_valid = d_val[cur];
        bus.s_data  = d_dat[cur];
        bus.s_last  = d_last[cur];
        @(negedge clk);
        chk("sym_nibble", {4'h0, bus.sym_nibble}, {4'h0, e_nib[cur]});
        chk("sym_valid", {7'h0, bus.sym_valid}, {7'h0, e_sv[cur]});
        chk("tx_active", {7'h0, bus.tx_active}, {7'h0, e_tx[cur]});
        chk("s_ready", {7'h0, bus.s_ready}, {7'h0, e_rdy[cur]});
        chk("underrun", {7'h0, bus.underrun}, {7'h0, e_ur[cur]});
        if (bus.s_valid && bus.s_ready) acc++;
        @(posedge clk);
        #1;
        cur++;
    endtask

    task automatic run_until(int last);
        while (cur <= last) step();
    endtask

    task automatic burst(string tag, int n, int absent, int mode);
        int e;
        acc = 0;
        e = plan(cur, n, absent, mode);
        run_until(e - 1);
        chk(tag, 8'(acc), 8'((absent < 0) ? n : absent));
    endtask

    task automatic rand_bytes(int n);
        for (int i = 0; i < n; i++) bq[i] = 8'($urandom);
    endtask

    int r;
    int n1;
    int ab;

    initial begin
        rst         = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        bus.s_last  = 1'b0;
        cur    = 0;
        errs   = 0;
        checks = 0;
        acc    = 0;
        clear(0);
        repeat (2) @(posedge clk);
        #1;

        bq[0] = 8'hA5;
        bq[1] = 8'h3C;
        burst("bytes_nominal", 2, -1, 2);
        step();

        bq[0] = 8'h11;
        burst("bytes_underrun0", 1, 0, 0);
        step();

        bq[0] = 8'hB2;
        bq[1] = 8'h47;
        bq[2] = 8'h9E;
        burst("bytes_midrun", 3, 1, 1);
        step();

        bq[0] = 8'h96;
        burst("bytes_single", 1, -1, 1);
        step();

        bq[0] = 8'hA5;
        bq[1] = 8'h3C;
        r = cur + 22;
        void'(plan(cur, 2, -1, 2));
        d_rst[r] = 1'b1;
        run_until(r);
        clear(r + 1);
        run_until(r + 5);

        bq[0] = 8'hA5;
        bq[1] = 8'h3C;
        r = cur + 22;
        void'(plan(cur, 2, -1, 2));
        d_rst[r] = 1'b1;
        run_until(r);
        clear(r + 1);
        rand_bytes(3);
        burst("bytes_after_rst", 3, -1, 2);
        step();

        rand_bytes(2);
        burst("bytes_b2b_a", 2, -1, 2);
        rand_bytes(3);
        burst("bytes_b2b_b", 3, -1, 2);
        step();

        for (int i = 0; i < 12; i++) begin
            n1 = $urandom_range(1, 5);
            rand_bytes(n1);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n1 - 1) : -1;
            burst("bytes_rand", n1, ab, $urandom_range(0, 2));
            repeat ($urandom_range(0, 2)) step();
        end
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/qam_symbol_scheduler.md
Name: qam_symbol_scheduler

Overview:
- Frames a byte stream into 4-bit symbols for the 16-QAM constellation mapper.
- Each burst is sequenced as PREAMBLE, then PAYLOAD, then GUARD. Every symbol is held for SYM_DIV clocks.
- A valid/ready handshake throttles the byte source. A one-cycle strobe marks each new symbol.
- Sits between the byte/packet source and the constellation mapper. sym_nibble drives the mapper's 4-bit parallel input directly.

Parameters:
- SYM_DIV, 4, clocks per symbol; legal range 2..256.
- PREAMBLE_LEN, 8, preamble symbols per burst; legal range 2..255, even.
- GUARD_LEN, 2, guard symbols after the payload; legal range 1..255.
- PRE_A, 4'h0, preamble nibble on even preamble index (index starts at 0).
- PRE_B, 4'hF, preamble nibble on odd preamble index.

Ports:
- clk, in, 1, system clock; all logic on the rising edge.
- rst, in, 1, synchronous, active-high reset.
- s_data, in, 8, payload byte; high nibble is sent first.
- s_valid, in, 1, s_data is valid.
- s_last, in, 1, qualifies s_data as the final byte of the burst.
- s_ready, out, 1, byte is consumed on a clock edge where s_valid && s_ready.
- sym_nibble, out, 4, current symbol to the mapper; {s3,s2,s1,s0}.
- sym_valid, out, 1, one-cycle strobe on the first clock of each transmitted symbol.
- tx_active, out, 1, high while in PREAMBLE or PAYLOAD; low in GUARD and IDLE.
- underrun, out, 1, one-cycle pulse when a needed byte is absent.

Behaviour:
- Reset (rst=1 at an edge, any state, including mid-burst): state=IDLE, cnt=0, idx=0, nib_sel=0, sym_nibble=0, sym_valid=0, s_ready=0, tx_active=0, underrun=0. Any partially sent byte is discarded.
- Divider: cnt runs 0..SYM_DIV-1 in every non-IDLE state. tick = (cnt==SYM_DIV-1). cnt returns to 0 on tick and on every state entry.
- IDLE: s_ready=0. s_valid=1 starts a burst without consuming the byte. Next edge: PREAMBLE, idx=0, sym_nibble=PRE_A, sym_valid=1 for that first cycle.
- PREAMBLE:
  - On tick with idx<PREAMBLE_LEN-1: idx++, sym_nibble=PRE_A/PRE_B by the new idx parity, sym_valid pulse.
  - On tick with idx==PREAMBLE_LEN-1: byte-fetch point.
- Byte-fetch point: s_ready is combinationally 1 in exactly that cycle (tick && byte needed). It is 0 in all other cycles.
  - If s_valid=1: latch s_data and s_last, sym_nibble=s_data[7:4], nib_sel=1, state=PAYLOAD, sym_valid pulse.
  - If s_valid=0: underrun pulse next cycle, state=GUARD, sym_valid=0.
- PAYLOAD:
  - On tick with nib_sel=1: sym_nibble=latched[3:0], nib_sel=0, sym_valid pulse.
  - On tick with nib_sel=0 and latched last=0: byte-fetch point.
  - On tick with nib_sel=0 and latched last=1: state=GUARD, idx=0.
- GUARD: sym_valid=0 and sym_nibble=0 throughout. On tick, idx++. On tick with idx==GUARD_LEN-1, state=IDLE.
- IDLE is entered with cnt=0. A new burst may start on the next cycle.
- s_last=1 on the very first byte gives a one-byte payload (2 symbols).
- Latency from the IDLE s_valid edge to the first preamble strobe is 1 clock.
- Source contract: s_data/s_last must be stable while s_valid=1 and unaccepted. Holding s_valid after an underrun starts a new burst once back in IDLE.
- Registered outputs: sym_nibble, sym_valid, underrun, tx_active. s_ready is combinational from state, cnt, nib_sel and latched last.

Test Plan:
- Nominal burst, SYM_DIV=4, PREAMBLE_LEN=4, GUARD_LEN=2:
  - Stimulus: s_valid rises at cycle 0 with bytes 0xA5 then 0x3C (s_last=1 on 0x3C).
  - Strobes at cycles 1/5/9/13 with nibbles 0,F,0,F. s_ready=1 at cycles 16 and 24.
  - Nibbles A@17, 5@21, 3@25, C@29. tx_active falls at 33. IDLE at 41. No sym_valid in 33..40.
- Underrun at the first byte: same setup, s_valid pulsed 1 at cycle 0 only, then 0.
  - Required: underrun=1 at cycle 17, GUARD from 17, IDLE at 25, no payload strobes.
- Mid-payload underrun: 3-byte burst with s_valid dropped before the second byte.
  - Required: underrun pulse exactly SYM_DIV cycles after the first byte's low-nibble strobe, then GUARD.
- Single-byte burst: byte 0x96 with s_last=1.
  - Required: nibbles 9 then 6, then GUARD; s_ready high exactly once.
- Reset mid-PAYLOAD: rst=1 for 1 cycle during the nibble 5 hold.
  - Required: all outputs 0 on the next cycle. With s_valid low, no strobe. With s_valid held, preamble restarts at PRE_A.
- Back-to-back bursts: s_valid held continuously across two framed bursts.
  - Required: second preamble strobe 1 cycle after IDLE entry. Byte counts and nibble order match a reference model.
